uart_bus_bridge: RTL and testbench

Serial-to-bus command bridge: consumes received bytes from a UART Rx FIFO, decodes a binary command protocol, and issues single read or write transactions on a simple bus-master handshake. Read data and status bytes go back through a UART Tx FIFO. It is the host-facing counterpart of the bus-mapped UART peripheral: the serial side drives the bus instead of the bus driving the serial line. It sits between `uart` + `fifo_sync_late` instances and the bus master port.

---
 rtl/uart_bus_bridge_if.sv | 29 ++
 rtl/uart_bus_bridge.sv | 139 +++++++++++++
 tb/tb_uart_bus_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_bridge_if.sv
// UART-FIFO / bus-master signal bundle for uart_bus_bridge.
// master: bridge side; slave: the FIFOs and bus fabric around it.
interface uart_bus_bridge_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    logic [7:0]           rx_rd_data;
    logic                 rx_ne;
    logic                 rx_re;
    logic [7:0]           tx_wr_data;
    logic                 tx_we;
    logic                 tx_full;
    logic [ADDRWIDTH-1:0] mst_addr;
    logic [DATAWIDTH-1:0] mst_wr_data;
    logic                 mst_we;
    logic                 mst_re;
    logic [DATAWIDTH-1:0] mst_rd_data;
    logic                 mst_ack;

    modport master (
        input  rx_rd_data, rx_ne, tx_full, mst_rd_data, mst_ack,
        output rx_re, tx_wr_data, tx_we, mst_addr, mst_wr_data, mst_we, mst_re
    );

    modport slave (
        output rx_rd_data, rx_ne, tx_full, mst_rd_data, mst_ack,
        input  rx_re, tx_wr_data, tx_we, mst_addr, mst_wr_data, mst_we, mst_re
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// Serial-to-bus command bridge. Decodes 'W' addr data / 'R' addr commands
// from the Rx FIFO, runs one bus transaction, replies through the Tx FIFO.
// Optional macro UART_BRIDGE_TIMEOUT_EN adds a bus ack timeout ('!' reply);
// without it BUS waits for mst_ack indefinitely.
module uart_bus_bridge #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic              bus_clk,
    input  logic              reset_l,
    uart_bus_bridge_if.master bus
);
    localparam int AB = ADDRWIDTH / 8;
    localparam int DB = DATAWIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
    typedef enum logic [1:0] {R_PLUS, R_QUES, R_BANG, R_DATA} rsp_t;

    state_t               state, state_n;
    rsp_t                 rsp_kind;
    logic [7:0]           cnt;
    logic [7:0]           rsp_left;
    logic                 is_wr;
    logic                 strb_q;
    logic                 tmo_hit;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [DATAWIDTH-1:0] rd_q;

    wire cmd_ok = (bus.rx_rd_data == 8'h57) || (bus.rx_rd_data == 8'h52);

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // expiry on the BUS cycle where the wait count reaches TIMEOUT; ack wins
    assign tmo_hit = (state == S_BUS) && !bus.mst_ack && (tmo_cnt == 16'(TIMEOUT - 1));

    // timeout counter: zero in the strobe cycle, +1 per BUS cycle without ack
    always_ff @(posedge bus_clk or negedge reset_l) begin
        if (!reset_l)
            tmo_cnt <= '0;
        else if (state != S_BUS)
            tmo_cnt <= '0;
        else if (!bus.mst_ack)
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT;
    assign tmo_hit    = 1'b0;
`endif

    // state register
    always_ff @(posedge bus_clk or negedge reset_l) begin
        if (!reset_l) state <= S_IDLE;
        else          state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.rx_ne) state_n = cmd_ok ? S_ADDR : S_RESP;
            S_ADDR: if (bus.rx_ne && cnt == 8'(AB - 1)) state_n = is_wr ? S_DATA : S_BUS;
            S_DATA: if (bus.rx_ne && cnt == 8'(DB - 1)) state_n = S_BUS;
            S_BUS:  if (bus.mst_ack || tmo_hit) state_n = S_RESP;
            S_RESP: if (!bus.tx_full && rsp_left == 8'd1) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // datapath: byte collection, read-data latch, reply sequencing
    always_ff @(posedge bus_clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt      <= '0;
            rsp_left <= '0;
            rsp_kind <= R_PLUS;
            is_wr    <= 1'b0;
            strb_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
        end else begin
            strb_q <= (state_n == S_BUS) && (state != S_BUS);
            case (state)
                S_IDLE: if (bus.rx_ne) begin
                    is_wr    <= (bus.rx_rd_data == 8'h57);
                    cnt      <= '0;
                    rsp_kind <= R_QUES;
                    rsp_left <= 8'd1;
                end
                S_ADDR: if (bus.rx_ne) begin
                    addr_q <= (addr_q << 8) | ADDRWIDTH'(bus.rx_rd_data);
                    cnt    <= (cnt == 8'(AB - 1)) ? 8'd0 : cnt + 8'd1;
                end
                S_DATA: if (bus.rx_ne) begin
                    wdata_q <= (wdata_q << 8) | DATAWIDTH'(bus.rx_rd_data);
                    cnt     <= (cnt == 8'(DB - 1)) ? 8'd0 : cnt + 8'd1;
                end
                S_BUS: if (bus.mst_ack) begin
                    rd_q     <= bus.mst_rd_data;
                    rsp_kind <= is_wr ? R_PLUS : R_DATA;
                    rsp_left <= is_wr ? 8'd1 : 8'(DB);
                end else if (tmo_hit) begin
                    rsp_kind <= R_BANG;
                    rsp_left <= 8'd1;
                end
                S_RESP: if (!bus.tx_full) begin
                    rsp_left <= rsp_left - 8'd1;
                    if (rsp_kind == R_DATA) rd_q <= rd_q << 8;
                end
                default: ;
            endcase
        end
    end

    // outputs: FIFO handshakes, reply byte select, one-cycle bus strobes
    always_comb begin
        bus.rx_re      = 1'b0;
        bus.tx_we      = 1'b0;
        bus.tx_wr_data = 8'h00;
        if (state == S_IDLE || state == S_ADDR || state == S_DATA)
            bus.rx_re = bus.rx_ne;
        if (state == S_RESP) begin
            bus.tx_we = !bus.tx_full;
            case (rsp_kind)
                R_PLUS:  bus.tx_wr_data = 8'h2B;
                R_QUES:  bus.tx_wr_data = 8'h3F;
                R_BANG:  bus.tx_wr_data = 8'h21;
                default: bus.tx_wr_data = rd_q[DATAWIDTH-1 -: 8];
            endcase
        end
        bus.mst_we      = strb_q && is_wr;
        bus.mst_re      = strb_q && !is_wr;
        bus.mst_addr    = addr_q;
        bus.mst_wr_data = wdata_q;
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes Rx bytes plus the
// expected strobes and Tx bytes; a monitor pops and compares.
module tb_uart_bus_bridge;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic bus_clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 bus_clk = ~bus_clk;

    uart_bus_bridge_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bif();

    uart_bus_bridge #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
        .bus_clk (bus_clk),
        .reset_l (reset_l),
        .bus     (bif.master)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } strb_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  expq[$];
    strb_t       sq[$];
    int          ack_dly = 0;
    int          ack_cnt = -1;
    logic [DW-1:0] rd_val = '0;
    bit          toggle_full = 1'b0;
    bit          ack_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rxq.push_back(8'h57);
        for (int i = AW/8 - 1; i >= 0; i--) rxq.push_back(a[i*8 +: 8]);
        for (int i = DW/8 - 1; i >= 0; i--) rxq.push_back(d[i*8 +: 8]);
        sq.push_back('{we: 1'b1, addr: a, data: d});
        expq.push_back(8'h2B);
    endtask

    task automatic send_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd_val = d;
        rxq.push_back(8'h52);
        for (int i = AW/8 - 1; i >= 0; i--) rxq.push_back(a[i*8 +: 8]);
        sq.push_back('{we: 1'b0, addr: a, data: '0});
        for (int i = DW/8 - 1; i >= 0; i--) expq.push_back(d[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rxq.size() != 0 || expq.size() != 0 || sq.size() != 0) && n < 2000) begin
            @(negedge bus_clk);
            n++;
        end
        if (n >= 2000) fail_now({name, "_stuck"});
        repeat (4) @(negedge bus_clk);
    endtask

    // FIFO and bus-slave model: drive inputs at negedge, react 1 ns later
    initial begin
        logic [7:0] popped;
        bif.rx_ne       = 1'b0;
        bif.rx_rd_data  = 8'h00;
        bif.tx_full     = 1'b0;
        bif.mst_ack     = 1'b0;
        bif.mst_rd_data = '0;
        forever begin
            @(negedge bus_clk);
            bif.mst_ack    = 1'b0;
            bif.tx_full    = toggle_full ? ~bif.tx_full : 1'b0;
            bif.rx_ne      = (rxq.size() != 0);
            bif.rx_rd_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
            #1;
            if (bif.rx_re && reset_l && rxq.size() != 0) popped = rxq.pop_front();
            if ((bif.mst_we || bif.mst_re) && ack_dly >= 0) ack_cnt = ack_dly;
            if (ack_now) begin
                ack_now         = 1'b0;
                bif.mst_ack     = 1'b1;
                bif.mst_rd_data = 32'h1111_1111;
            end else if (ack_cnt == 0) begin
                bif.mst_ack     = 1'b1;
                bif.mst_rd_data = rd_val;
                ack_cnt         = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
            end
        end
    end

    // monitor: every Tx push and bus strobe is checked against the queues
    initial begin
        bit    prev_strb = 1'b0;
        strb_t s;
        forever begin
            @(negedge bus_clk);
            #1;
            if (bif.tx_we) begin
                if (expq.size() == 0) fail_now("tx_unexpected");
                else chk("tx_byte", 64'(bif.tx_wr_data), 64'(expq.pop_front()));
            end
            if (bif.mst_we || bif.mst_re) begin
                if (prev_strb) fail_now("strobe_long");
                if (sq.size() == 0) fail_now("strobe_unexpected");
                else begin
                    s = sq.pop_front();
                    chk("strobe_kind", 64'({bif.mst_we, bif.mst_re}), s.we ? 64'd2 : 64'd1);
                    chk("strobe_addr", 64'(bif.mst_addr), 64'(s.addr));
                    if (s.we) chk("strobe_wdata", 64'(bif.mst_wr_data), 64'(s.data));
                end
            end
            prev_strb = bif.mst_we || bif.mst_re;
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge bus_clk);
        #1;
        chk("rst_rx_re",    64'(bif.rx_re), 64'd0);
        chk("rst_tx_we",    64'(bif.tx_we), 64'd0);
        chk("rst_mst_we",   64'(bif.mst_we), 64'd0);
        chk("rst_mst_re",   64'(bif.mst_re), 64'd0);
        chk("rst_tx_data",  64'(bif.tx_wr_data), 64'd0);
        chk("rst_mst_addr", 64'(bif.mst_addr), 64'd0);
        chk("rst_mst_wdat", 64'(bif.mst_wr_data), 64'd0);
        @(negedge bus_clk);
        reset_l = 1'b1;

        // write, ack in the strobe cycle
        ack_dly = 0;
        send_write(32'h1234_5678, 32'hDEAD_BEEF);
        wait_idle("write");
        chk("addr_hold",  64'(bif.mst_addr), 64'h1234_5678);
        chk("wdata_hold", 64'(bif.mst_wr_data), 64'hDEAD_BEEF);

        // read, ack three cycles after the strobe
        ack_dly = 3;
        send_read(32'h0000_0010, 32'hCAFE_F00D);
        wait_idle("read");

        // read reply under Tx backpressure
        ack_dly     = 1;
        toggle_full = 1'b1;
        send_read(32'h0000_0020, 32'h01A2_B3C4);
        wait_idle("backpressure");
        toggle_full = 1'b0;

        // bad command byte, then a valid read
        ack_dly = 0;
        rxq.push_back(8'h41);
        expq.push_back(8'h3F);
        send_read(32'h0000_0030, 32'h89AB_CDEF);
        wait_idle("badcmd");

        // stray ack while idle is ignored
        ack_now = 1'b1;
        repeat (3) @(negedge bus_clk);
        send_write(32'hA5A5_0004, 32'h0BAD_CAFE);
        wait_idle("stray_ack");

`ifdef UART_BRIDGE_TIMEOUT_EN
        // timeout: read with no ack gets only '!'; a late ack is ignored
        ack_dly = -1;
        rxq.push_back(8'h52);
        rxq.push_back(8'h00); rxq.push_back(8'h00);
        rxq.push_back(8'h00); rxq.push_back(8'h40);
        sq.push_back('{we: 1'b0, addr: 32'h0000_0040, data: '0});
        expq.push_back(8'h21);
        wait_idle("timeout");
        ack_now = 1'b1;
        repeat (3) @(negedge bus_clk);
        ack_dly = 0;
        send_read(32'h0000_0044, 32'h7654_3210);
        wait_idle("after_timeout");
`endif

        // reset after three bytes of a write: no strobe, no reply
        ack_dly = 0;
        rxq.push_back(8'h57);
        rxq.push_back(8'h12);
        rxq.push_back(8'h34);
        n = 0;
        while (rxq.size() != 0 && n < 100) begin
            @(negedge bus_clk);
            n++;
        end
        if (n >= 100) fail_now("rst_feed_stuck");
        repeat (2) @(negedge bus_clk);
        reset_l = 1'b0;
        @(negedge bus_clk);
        #1;
        chk("midrst_addr", 64'(bif.mst_addr), 64'd0);
        @(negedge bus_clk);
        reset_l = 1'b1;
        repeat (10) @(negedge bus_clk);
        send_write(32'h0000_0100, 32'h5555_AAAA);
        wait_idle("after_reset");

        chk("expq_empty", 64'(expq.size()), 64'd0);
        chk("sq_empty",   64'(sq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
